// File: rtl/matrix_link_host.sv
// Host-side initiator for the 3x3 matrix-multiply link: serialises A and B into
// a 10-byte request over a byte UART, then gathers the 9 result bytes.
module matrix_link_host #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [35:0] a_flat,
    input  logic [35:0] b_flat,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [71:0] c_flat,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STRT    = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_RECV    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [35:0]      a_q;
    logic [35:0]      b_q;
    logic [3:0]       k;
    logic [3:0]       ridx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow [8];
    logic [7:0]       byte_sel;

    // Two adjacent 4-bit elements share a byte, even element in the low nibble,
    // so bytes 0..3 and 5..8 are plain slices of the latched flat vectors.
    always_comb begin
        byte_sel = 8'h00;
        case (k)
            4'd0:    byte_sel = a_q[7:0];
            4'd1:    byte_sel = a_q[15:8];
            4'd2:    byte_sel = a_q[23:16];
            4'd3:    byte_sel = a_q[31:24];
            4'd4:    byte_sel = {4'h0, a_q[35:32]};
            4'd5:    byte_sel = b_q[7:0];
            4'd6:    byte_sel = b_q[15:8];
            4'd7:    byte_sel = b_q[23:16];
            4'd8:    byte_sel = b_q[31:24];
            4'd9:    byte_sel = {4'h0, b_q[35:32]};
            default: byte_sel = 8'h00;
        endcase
    end

    assign tx_start = (state == S_STRT);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k       <= '0;
            ridx    <= '0;
            cnt     <= '0;
            tx_data <= '0;
            c_flat  <= '0;
            err     <= 1'b0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a_flat;
                        b_q   <= b_flat;
                        err   <= 1'b0;
                        k     <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_data <= byte_sel;
                    if (!tx_busy) state <= S_STRT;
                end
                S_STRT: state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (tx_busy) state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (k == 4'd9) begin
                            ridx  <= '0;
                            cnt   <= '0;
                            state <= S_RECV;
                        end else begin
                            k     <= k + 4'd1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_RECV: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rx_ready) begin
                        cnt <= '0;
                        if (ridx == 4'd8) begin
                            c_flat <= {rx_data, shadow[7], shadow[6], shadow[5], shadow[4],
                                       shadow[3], shadow[2], shadow[1], shadow[0]};
                            state  <= S_DONE;
                        end else begin
                            shadow[ridx[2:0]] <= rx_data;
                            ridx              <= ridx + 4'd1;
                        end
                    end else if (cnt == CNT_LIMIT) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_link_host.sv
// Directed bench for matrix_link_host: UART tx_busy model, byte capture,
// hand-computed request streams and result vectors.
module tb_matrix_link_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [35:0] a_flat;
    logic [35:0] b_flat;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [71:0] c_flat;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int passed = 0;

    int   busy_left  = 0;
    int   busy_len   = 10;
    logic force_busy = 1'b0;
    int   start_cnt  = 0;
    int   done_cnt   = 0;
    logic prev_start = 1'b0;
    bit   dbl_start  = 1'b0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];

    matrix_link_host #(.TIMEOUT_CYCLES(50), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_ready(rx_ready), .c_flat(c_flat),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: busy for busy_len cycles after each tx_start.
    always @(negedge clk) begin
        if (rst) begin
            busy_left  = 0;
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                cap_q.push_back(tx_data);
                start_cnt++;
                if (prev_start) dbl_start = 1'b1;
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (done) done_cnt++;
            prev_start = tx_start;
        end
        tx_busy = force_busy || (busy_left > 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [35:0] a, input logic [35:0] b);
        cap_q.delete();
        start_cnt = 0;
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a_flat = ~a;
        b_flat = b ^ 36'h5A5A5A5A5;
    endtask

    task automatic wait_send(input bit strays, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rx_ready = 1'b0;
            start    = 1'b0;
            if (start_cnt == 10 && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            if (strays && (i % 7 == 3)) begin
                rx_data  = 8'hEE;
                rx_ready = 1'b1;
                start    = 1'b1;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_data  = d;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        a_flat = '0; b_flat = '0;
        repeat (3) tick();
        checks++;
        if ({busy, tx_start, tx_data, c_flat, done, err} !== 84'h0)
            $display("FAIL reset_outputs: got busy=%b txs=%b txd=%h c=%h done=%b err=%b want all 0",
                     busy, tx_start, tx_data, c_flat, done, err);
        else passed++;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] got;
        int d0;
        busy_len = 10;
        start_txn(36'h987654321, 36'h100010001);
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
        else passed++;
        wait_send(1'b0, ok);
        checks++;
        if (!ok) $display("FAIL basic_send_timeout: sent %0d bytes want 10", start_cnt);
        else passed++;
        exp_q = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h09, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        checks++;
        if (cap_q.size() != 10) $display("FAIL basic_count: got %0d want 10", cap_q.size());
        else passed++;
        for (int i = 0; i < 10; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        tick();
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) send_rx(8'h01 + 8'(i));
        checks++;
        if ({done, err, c_flat} !== {1'b1, 1'b0, 72'h090807060504030201})
            $display("FAIL basic_result: done=%b err=%b c=%h want 1 0 090807060504030201", done, err, c_flat);
        else passed++;
        tick();
        checks++;
        if ({done, busy} !== 2'b00 || done_cnt != d0 + 1)
            $display("FAIL basic_done_pulse: done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_allf_then_second();
        bit ok;
        logic [7:0] got;
        start_txn(36'hFFFFFFFFF, 36'hFFFFFFFFF);
        wait_send(1'b0, ok);
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        for (int i = 0; i < 10; i++) begin
            got = (ok && i < cap_q.size()) ? cap_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL allf_byte%0d: got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        tick();
        repeat (9) send_rx(8'hA3);
        checks++;
        if ({done, c_flat} !== {1'b1, {9{8'hA3}}})
            $display("FAIL allf_result: done=%b c=%h want 1 a3a3a3a3a3a3a3a3a3", done, c_flat);
        else passed++;
        tick();
        start_txn(36'h123456789, 36'h0A5A5A5A5);
        wait_send(1'b0, ok);
        exp_q = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        for (int i = 0; i < 10; i++) begin
            got = (ok && i < cap_q.size()) ? cap_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL second_byte%0d: got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        tick();
        for (int i = 0; i < 8; i++) send_rx(8'h10 + 8'(i));
        checks++;
        if (c_flat !== {9{8'hA3}}) $display("FAIL second_retain: c=%h want a3a3a3a3a3a3a3a3a3", c_flat);
        else passed++;
        send_rx(8'h18);
        checks++;
        if ({done, c_flat} !== {1'b1, 72'h181716151413121110})
            $display("FAIL second_result: done=%b c=%h want 1 181716151413121110", done, c_flat);
        else passed++;
        tick();
    endtask

    task automatic test_timeout_and_coincident();
        bit ok;
        int d0;
        start_txn(36'h111111111, 36'h222222222);
        wait_send(1'b0, ok);
        tick();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_rx(8'h31 + 8'(i));
        repeat (49) tick();
        checks++;
        if ({err, busy} !== 2'b01) $display("FAIL timeout_early: err=%b busy=%b want 0 1", err, busy);
        else passed++;
        tick();
        checks++;
        if ({err, busy} !== 2'b10) $display("FAIL timeout_expiry: err=%b busy=%b want 1 0", err, busy);
        else passed++;
        repeat (3) tick();
        checks++;
        if ({err, c_flat} !== {1'b1, 72'h181716151413121110} || done_cnt != d0)
            $display("FAIL timeout_state: err=%b c=%h pulses=%0d want 1 181716151413121110 0",
                     err, c_flat, done_cnt - d0);
        else passed++;
        start_txn(36'h333333333, 36'h444444444);
        checks++;
        if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err);
        else passed++;
        wait_send(1'b0, ok);
        tick();
        for (int i = 0; i < 3; i++) send_rx(8'h41 + 8'(i));
        repeat (49) tick();
        send_rx(8'h44);
        checks++;
        if ({err, busy} !== 2'b01) $display("FAIL coincident_accept: err=%b busy=%b want 0 1", err, busy);
        else passed++;
        for (int i = 4; i < 9; i++) send_rx(8'h41 + 8'(i));
        checks++;
        if ({done, err, c_flat} !== {1'b1, 1'b0, 72'h494847464544434241})
            $display("FAIL coincident_result: done=%b err=%b c=%h want 1 0 494847464544434241", done, err, c_flat);
        else passed++;
        tick();
    endtask

    task automatic test_busy_and_strays();
        bit ok;
        logic [7:0] got;
        force_busy = 1'b1;
        tick();
        start_txn(36'h876543210, 36'h000000000);
        for (int i = 0; i < 20; i++) begin
            rx_data  = 8'hEE;
            rx_ready = (i % 5 == 2);
            start    = (i % 5 == 2);
            tick();
        end
        rx_ready = 1'b0;
        start    = 1'b0;
        checks++;
        if (start_cnt != 0 || busy !== 1'b1)
            $display("FAIL busy_hold: tx_starts=%0d busy=%b want 0 1", start_cnt, busy);
        else passed++;
        force_busy = 1'b0;
        wait_send(1'b1, ok);
        checks++;
        if (!ok || cap_q.size() != 10) $display("FAIL strays_count: got %0d bytes want 10", cap_q.size());
        else passed++;
        exp_q = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL strays_byte%0d: got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        tick();
        for (int i = 0; i < 9; i++) send_rx(8'hC0 + 8'(i));
        checks++;
        if ({done, c_flat} !== {1'b1, 72'hC8C7C6C5C4C3C2C1C0})
            $display("FAIL strays_result: done=%b c=%h want 1 c8c7c6c5c4c3c2c1c0", done, c_flat);
        else passed++;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL strays_idle: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_txn(36'h987654321, 36'h100010001);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (start_cnt == 7) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) tick();
        checks++;
        if (!ok || tx_busy !== 1'b1) $display("FAIL rstmid_reach: bytes=%0d tx_busy=%b want 7 1", start_cnt, tx_busy);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, tx_start, tx_data, c_flat, done, err} !== 84'h0)
            $display("FAIL rstmid_outputs: busy=%b txs=%b txd=%h c=%h done=%b err=%b want all 0",
                     busy, tx_start, tx_data, c_flat, done, err);
        else passed++;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        start_txn(36'h987654321, 36'h100010001);
        wait_send(1'b0, ok);
        checks++;
        if (!ok || cap_q.size() != 10 || cap_q[0] !== 8'h21)
            $display("FAIL rstmid_restart: bytes=%0d first=%h want 10 21", cap_q.size(),
                     (cap_q.size() > 0) ? cap_q[0] : 8'hxx);
        else passed++;
        tick();
        for (int i = 0; i < 9; i++) send_rx(8'h61 + 8'(i));
        checks++;
        if ({done, c_flat} !== {1'b1, 72'h696867666564636261})
            $display("FAIL rstmid_result: done=%b c=%h want 1 696867666564636261", done, c_flat);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_allf_then_second();
        test_timeout_and_coincident();
        test_busy_and_strays();
        test_reset_mid();
        checks++;
        if (dbl_start !== 1'b0) $display("FAIL tx_start_spacing: back-to-back tx_start got %b want 0", dbl_start);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
